// File: rtl/nrf_spi_pkg.sv
// ============================================================================
// Module      : nrf_spi_pkg
// Description : Shared types and constants for the nRF24L01 SPI master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nrf_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_NEXT  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } nrf_spi_state_t;

    localparam int NRF_SPI_BITS           = 8;
    localparam int NRF_SPI_TICKS_PER_BYTE = 16;

endpackage : nrf_spi_pkg

`default_nettype wire

// File: rtl/nrf_spi_master_if.sv
// ============================================================================
// Module      : nrf_spi_master_if
// Description : Byte handshake and SPI pin bundle for nrf_spi_master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nrf_spi_master_if;
    import nrf_spi_pkg::*;

    logic                    tick;
    logic                    tx_valid;
    logic [NRF_SPI_BITS-1:0] tx_data;
    logic                    tx_last;
    logic                    tx_ready;
    logic                    rx_valid;
    logic [NRF_SPI_BITS-1:0] rx_data;
    logic                    busy;
    logic                    sck;
    logic                    mosi;
    logic                    miso;
    logic                    csn;

    modport master (
        input  tick, tx_valid, tx_data, tx_last, miso,
        output tx_ready, rx_valid, rx_data, busy, sck, mosi, csn
    );

    modport slave (
        output tick, tx_valid, tx_data, tx_last, miso,
        input  tx_ready, rx_valid, rx_data, busy, sck, mosi, csn
    );

endinterface : nrf_spi_master_if

`default_nettype wire

// File: rtl/nrf_spi_master.sv
// ============================================================================
// Module      : nrf_spi_master
// Description : Mode-0 MSB-first byte SPI master paced by an external tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nrf_spi_master
    import nrf_spi_pkg::*;
#(
    parameter int CSN_SETUP_TICKS = 2,
    parameter int CSN_HOLD_TICKS  = 2,
    parameter int CSN_IDLE_TICKS  = 4
) (
    input  wire logic         clk_50,
    input  wire logic         rst,
    nrf_spi_master_if.master  bus
);

    localparam int DLY_W = 16;

    nrf_spi_state_t          r_state, w_state_nxt;
    logic [3:0]              r_tick_cnt, w_tick_cnt_nxt;
    logic [DLY_W-1:0]        r_dly_cnt, w_dly_cnt_nxt;
    logic [NRF_SPI_BITS-1:0] r_tx_sh, w_tx_sh_nxt;
    logic [NRF_SPI_BITS-1:0] r_rx_sh, w_rx_sh_nxt;
    logic [NRF_SPI_BITS-1:0] r_rx_data, w_rx_data_nxt;
    logic                    r_rx_valid, w_rx_valid_nxt;
    logic                    r_last, w_last_nxt;
    logic                    r_sck, w_sck_nxt;
    logic                    r_mosi, w_mosi_nxt;
    logic                    r_csn, w_csn_nxt;
    logic                    r_tx_ready, w_tx_ready_nxt;
    logic                    r_busy, w_busy_nxt;
    logic                    w_accept;
    logic                    w_byte_done;

    // r_tx_ready is high only in IDLE and NEXT, so it also gates acceptance
    assign w_accept    = bus.tx_valid && r_tx_ready;
    assign w_byte_done = (r_tick_cnt == 4'(NRF_SPI_TICKS_PER_BYTE - 1));

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_tick_cnt_nxt = r_tick_cnt;
        w_dly_cnt_nxt  = r_dly_cnt;
        w_tx_sh_nxt    = r_tx_sh;
        w_rx_sh_nxt    = r_rx_sh;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_last_nxt     = r_last;
        w_sck_nxt      = r_sck;
        w_mosi_nxt     = r_mosi;
        w_csn_nxt      = r_csn;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_tx_sh_nxt   = bus.tx_data;
                    w_mosi_nxt    = bus.tx_data[NRF_SPI_BITS-1];
                    w_last_nxt    = bus.tx_last;
                    w_csn_nxt     = 1'b0;
                    w_dly_cnt_nxt = '0;
                    w_state_nxt   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (bus.tick) begin
                    if (r_dly_cnt == DLY_W'(CSN_SETUP_TICKS - 1)) begin
                        w_dly_cnt_nxt  = '0;
                        w_tick_cnt_nxt = '0;
                        w_state_nxt    = ST_SHIFT;
                    end else begin
                        w_dly_cnt_nxt = r_dly_cnt + 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (bus.tick) begin
                    if (!r_tick_cnt[0]) begin
                        w_sck_nxt      = 1'b1;
                        w_rx_sh_nxt    = {r_rx_sh[NRF_SPI_BITS-2:0], bus.miso};
                        w_tick_cnt_nxt = r_tick_cnt + 4'd1;
                    end else if (w_byte_done) begin
                        w_sck_nxt      = 1'b0;
                        w_rx_data_nxt  = r_rx_sh;
                        w_rx_valid_nxt = 1'b1;
                        w_tick_cnt_nxt = '0;
                        w_dly_cnt_nxt  = '0;
                        w_state_nxt    = r_last ? ST_HOLD : ST_NEXT;
                    end else begin
                        w_sck_nxt      = 1'b0;
                        w_mosi_nxt     = r_tx_sh[NRF_SPI_BITS-2];
                        w_tx_sh_nxt    = r_tx_sh << 1;
                        w_tick_cnt_nxt = r_tick_cnt + 4'd1;
                    end
                end
            end
            ST_NEXT: begin
                // CSN is already asserted, so the next byte skips the setup delay
                if (w_accept) begin
                    w_tx_sh_nxt    = bus.tx_data;
                    w_mosi_nxt     = bus.tx_data[NRF_SPI_BITS-1];
                    w_last_nxt     = bus.tx_last;
                    w_tick_cnt_nxt = '0;
                    w_state_nxt    = ST_SHIFT;
                end
            end
            ST_HOLD: begin
                if (bus.tick) begin
                    if (r_dly_cnt == DLY_W'(CSN_HOLD_TICKS - 1)) begin
                        w_csn_nxt     = 1'b1;
                        w_dly_cnt_nxt = '0;
                        w_state_nxt   = ST_GAP;
                    end else begin
                        w_dly_cnt_nxt = r_dly_cnt + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (bus.tick) begin
                    if (r_dly_cnt == DLY_W'(CSN_IDLE_TICKS - 1)) begin
                        w_dly_cnt_nxt = '0;
                        w_state_nxt   = ST_IDLE;
                    end else begin
                        w_dly_cnt_nxt = r_dly_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_csn_nxt   = 1'b1;
                w_sck_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_tx_ready_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_NEXT);
        w_busy_nxt     = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_dly_cnt  <= '0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_last     <= 1'b0;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_csn      <= 1'b1;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick_cnt_nxt;
            r_dly_cnt  <= w_dly_cnt_nxt;
            r_tx_sh    <= w_tx_sh_nxt;
            r_rx_sh    <= w_rx_sh_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_last     <= w_last_nxt;
            r_sck      <= w_sck_nxt;
            r_mosi     <= w_mosi_nxt;
            r_csn      <= w_csn_nxt;
            r_tx_ready <= w_tx_ready_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign bus.tx_ready = r_tx_ready;
    assign bus.rx_valid = r_rx_valid;
    assign bus.rx_data  = r_rx_data;
    assign bus.busy     = r_busy;
    assign bus.sck      = r_sck;
    assign bus.mosi     = r_mosi;
    assign bus.csn      = r_csn;

endmodule : nrf_spi_master

`default_nettype wire

// File: tb/tb_nrf_spi_master.sv
// ============================================================================
// Module      : tb_nrf_spi_master
// Description : Directed and randomized self-checking bench for nrf_spi_master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nrf_spi_master;
    import nrf_spi_pkg::*;

    localparam int C_SETUP = 2;
    localparam int C_HOLD  = 2;
    localparam int C_IDLE  = 4;

    logic clk_50 = 1'b0;
    logic rst    = 1'b1;

    nrf_spi_master_if bus ();

    nrf_spi_master #(
        .CSN_SETUP_TICKS (C_SETUP),
        .CSN_HOLD_TICKS  (C_HOLD),
        .CSN_IDLE_TICKS  (C_IDLE)
    ) dut (
        .clk_50 (clk_50),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_50 = ~clk_50;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Tick source: one pulse every tick_per cycles, or constantly high when tick_per <= 1
    int tick_per = 5;
    int tick_ph  = 0;
    initial begin
        bus.tick = 1'b0;
        forever begin
            @(posedge clk_50);
            #1;
            tick_ph  = tick_ph + 1;
            bus.tick = (tick_per <= 1) || ((tick_ph % tick_per) == 0);
        end
    end

    // SPI slave: loopback or a byte table presented MSB first, advanced on SCK falling
    logic       lb_en = 1'b1;
    logic [7:0] resp_arr [0:3];
    logic [7:0] s_bits = '0;
    logic       w_resp_bit;
    assign w_resp_bit = resp_arr[s_bits[4:3]][3'd7 - s_bits[2:0]];
    assign bus.miso   = lb_en ? bus.mosi : w_resp_bit;

    // Observation logs, written only here
    logic        prev_csn = 1'b1;
    logic        prev_sck = 1'b0;
    int unsigned cyc        = 0;
    int unsigned used_ticks = 0;
    int unsigned csn_falls  = 0;
    int unsigned gap_viol   = 0;
    int unsigned hi_ticks   = 0;
    logic        have_rise  = 1'b0;
    logic        mosi_log [$];
    int unsigned rise_log [$];
    logic [7:0]  rx_log   [$];
    int unsigned gap_log  [$];

    always @(negedge clk_50) begin
        cyc <= cyc + 1;
        if (prev_csn && !bus.csn)      s_bits <= '0;
        else if (prev_sck && !bus.sck) s_bits <= s_bits + 8'd1;
        if (!prev_sck && bus.sck) begin
            mosi_log.push_back(bus.mosi);
            rise_log.push_back(cyc);
        end
        if (bus.rx_valid) rx_log.push_back(bus.rx_data);
        // ticks the FSM actually consumes with CSN low: SETUP, SHIFT and HOLD
        if (bus.tick && !bus.csn && !bus.tx_ready) used_ticks <= used_ticks + 1;
        if (bus.csn && !prev_csn) begin
            hi_ticks  <= bus.tick ? 1 : 0;
            have_rise <= 1'b1;
        end else if (bus.csn && bus.tick) begin
            hi_ticks <= hi_ticks + 1;
        end
        if (!bus.csn && prev_csn) begin
            csn_falls <= csn_falls + 1;
            if (have_rise) gap_log.push_back(hi_ticks);
        end
        if (bus.csn && bus.busy && bus.tx_ready) gap_viol <= gap_viol + 1;
        prev_csn <= bus.csn;
        prev_sck <= bus.sck;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mbyte(input int base);
        logic [7:0] r;
        r = 'x;
        if (base + 8 <= mosi_log.size()) begin
            for (int k = 0; k < 8; k++) r[7-k] = mosi_log[base+k];
        end
        return r;
    endfunction

    function automatic logic [7:0] rxat(input int idx);
        logic [7:0] r;
        r = 'x;
        if (idx < rx_log.size()) r = rx_log[idx];
        return r;
    endfunction

    logic acc_rxv;

    task automatic send(input logic [7:0] d, input logic l);
        logic ok;
        ok           = 1'b0;
        bus.tx_data  = d;
        bus.tx_last  = l;
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk_50);
            if (bus.tx_ready) begin
                acc_rxv = bus.rx_valid;
                ok      = 1'b1;
            end
        end
        if (ok) begin
            @(posedge clk_50);
            #1;
        end
        bus.tx_valid = 1'b0;
        check("accept_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20000 && bus.busy; i++) @(negedge clk_50);
        check("idle_timeout", {31'd0, bus.busy}, 32'd0);
        repeat (3) @(posedge clk_50);
        #1;
    endtask

    int         mb, rb, ub, fb, gb, vb, kb, n;
    logic [7:0] txb [0:3];

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        bus.tx_last  = 1'b0;
        for (int k = 0; k < 4; k++) resp_arr[k] = '0;
        acc_rxv = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_50);
        #1;
        check("rst_csn",      {31'd0, bus.csn},      32'd1);
        check("rst_sck",      {31'd0, bus.sck},      32'd0);
        check("rst_mosi",     {31'd0, bus.mosi},     32'd0);
        check("rst_rx_data",  {24'd0, bus.rx_data},  32'd0);
        check("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("rst_busy",     {31'd0, bus.busy},     32'd0);
        check("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        rst = 1'b0;
        repeat (4) @(posedge clk_50);
        #1;

        // Single byte A5, loopback, tick every 5 cycles
        tick_per = 5; lb_en = 1'b1;
        mb = mosi_log.size(); rb = rx_log.size(); ub = used_ticks; fb = csn_falls;
        send(8'hA5, 1'b1);
        wait_idle();
        check("t1_mosi_bits", {24'd0, mbyte(mb)}, 32'hA5);
        check("t1_rx_data",   {24'd0, rxat(rb)},  32'hA5);
        check("t1_rx_count",  rx_log.size() - rb, 32'd1);
        check("t1_csn_ticks", used_ticks - ub,    C_SETUP + 16 + C_HOLD);

        // Two-byte read with table-driven MISO
        lb_en = 1'b0; resp_arr[0] = 8'h0E; resp_arr[1] = 8'h40;
        mb = mosi_log.size(); rb = rx_log.size(); ub = used_ticks; fb = csn_falls;
        send(8'h07, 1'b0);
        send(8'hFF, 1'b1);
        wait_idle();
        check("t2_rx0",       {24'd0, rxat(rb)},     32'h0E);
        check("t2_rx1",       {24'd0, rxat(rb+1)},   32'h40);
        check("t2_mosi0",     {24'd0, mbyte(mb)},    32'h07);
        check("t2_mosi1",     {24'd0, mbyte(mb+8)},  32'hFF);
        check("t2_csn_falls", csn_falls - fb,        32'd1);
        check("t2_csn_ticks", used_ticks - ub,       C_SETUP + 32 + C_HOLD);

        // Back-to-back transactions: CSN gap and tx_ready low during GAP
        lb_en = 1'b1;
        mb = mosi_log.size(); fb = csn_falls; gb = gap_log.size(); vb = gap_viol;
        send(8'h20, 1'b1);
        send(8'h61, 1'b1);
        wait_idle();
        check("t3_mosi0",     {24'd0, mbyte(mb)},   32'h20);
        check("t3_mosi1",     {24'd0, mbyte(mb+8)}, 32'h61);
        check("t3_csn_falls", csn_falls - fb,       32'd2);
        if (gap_log.size() > gb) check("t3_gap_ge_idle", {31'd0, gap_log[gb] >= C_IDLE}, 32'd1);
        else                     check("t3_gap_seen", gap_log.size() - gb, 32'd1);
        check("t3_ready_in_gap", gap_viol - vb, 32'd0);

        // Reset after the 5th SHIFT tick of C3
        rb = rx_log.size();
        send(8'hC3, 1'b1);
        n = 0;
        for (int i = 0; i < 2000 && n < C_SETUP + 5; i++) begin
            @(negedge clk_50);
            if (bus.tick) n++;
        end
        @(posedge clk_50);
        #1;
        check("t4_sck_high_before_rst", {31'd0, bus.sck}, 32'd1);
        rst = 1'b1;
        #1;
        check("t4_rst_csn",  {31'd0, bus.csn},  32'd1);
        check("t4_rst_sck",  {31'd0, bus.sck},  32'd0);
        check("t4_rst_busy", {31'd0, bus.busy}, 32'd0);
        repeat (3) @(posedge clk_50);
        #1;
        rst = 1'b0;
        repeat (200) @(posedge clk_50);
        #1;
        check("t4_no_rx_valid",  rx_log.size() - rb,      32'd0);
        check("t4_ready_after",  {31'd0, bus.tx_ready},   32'd1);

        // Tick tied high: SCK period of two clocks
        tick_per = 1; lb_en = 1'b1;
        mb = mosi_log.size(); rb = rx_log.size(); kb = rise_log.size();
        send(8'h3C, 1'b1);
        wait_idle();
        check("t5_rx_data", {24'd0, rxat(rb)}, 32'h3C);
        if (rise_log.size() >= kb + 8) begin
            check("t5_sck_period", rise_log[kb+1] - rise_log[kb], 32'd2);
            check("t5_sck_span",   rise_log[kb+7] - rise_log[kb], 32'd14);
        end else begin
            check("t5_sck_rises", rise_log.size() - kb, 32'd8);
        end

        // Next byte held valid through SHIFT is taken only in the rx_valid cycle
        tick_per = 3; lb_en = 1'b1;
        mb = mosi_log.size(); rb = rx_log.size();
        send(8'hAA, 1'b0);
        send(8'h55, 1'b1);
        check("t6_accept_in_rxv", {31'd0, acc_rxv}, 32'd1);
        wait_idle();
        check("t6_mosi0", {24'd0, mbyte(mb)},   32'hAA);
        check("t6_mosi1", {24'd0, mbyte(mb+8)}, 32'h55);
        check("t6_rx1",   {24'd0, rxat(rb+1)},  32'h55);

        // Randomized transactions against the byte-level model
        lb_en = 1'b0;
        for (int t = 0; t < 6; t++) begin
            tick_per = $urandom_range(1, 4);
            n = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) begin
                txb[k]      = 8'($urandom);
                resp_arr[k] = 8'($urandom);
            end
            mb = mosi_log.size(); rb = rx_log.size(); ub = used_ticks; fb = csn_falls;
            for (int k = 0; k < n; k++) send(txb[k], k == n - 1);
            wait_idle();
            for (int k = 0; k < n; k++) begin
                check("rnd_mosi", {24'd0, mbyte(mb + 8*k)}, {24'd0, txb[k]});
                check("rnd_rx",   {24'd0, rxat(rb + k)},    {24'd0, resp_arr[k]});
            end
            check("rnd_csn_ticks", used_ticks - ub, C_SETUP + 16*n + C_HOLD);
            check("rnd_csn_falls", csn_falls - fb,  32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_nrf_spi_master

`default_nettype wire
